// File: rtl/demo_de0_sys_lookahead_state_ram_mp_if.sv
// Bus bundle for the lookahead state RAM: one write port, NUM_RD_PORTS flattened read ports.
interface demo_de0_sys_lookahead_state_ram_mp_if #(
  parameter int unsigned DATA_WIDTH    = 2,
  parameter int unsigned NUM_SYMBOLS   = 1,
  parameter int unsigned ADDRESS_WIDTH = 1,
  parameter int unsigned NUM_RD_PORTS  = 1
);
  logic                                  clear;
  logic [ADDRESS_WIDTH-1:0]              wr_address;
  logic [DATA_WIDTH-1:0]                 wr_writedata;
  logic [NUM_SYMBOLS-1:0]                wr_byteenable;
  logic                                  wr_write;
  logic                                  wr_waitrequest;
  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_address;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_readdata;

  modport master (
    output clear, wr_address, wr_writedata, wr_byteenable, wr_write, rd_address,
    input  wr_waitrequest, rd_readdata
  );

  modport slave (
    input  clear, wr_address, wr_writedata, wr_byteenable, wr_write, rd_address,
    output wr_waitrequest, rd_readdata
  );
endinterface

// File: rtl/demo_de0_sys_lookahead_state_ram_mp.sv
// Multi-read-port state RAM with symbol write enables, write-to-read forwarding and a
// clear sweep that runs after reset and on request.
module demo_de0_sys_lookahead_state_ram_mp #(
  parameter int unsigned             DATA_WIDTH     = 2,
  parameter int unsigned             SYMBOL_WIDTH   = DATA_WIDTH,
  parameter int unsigned             DEPTH          = 1,
  parameter int unsigned             ADDRESS_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned             NUM_RD_PORTS   = 1,
  parameter bit                      CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = '0
) (
  input logic                                 clk,
  input logic                                 reset_n,
  demo_de0_sys_lookahead_state_ram_mp_if.slave bus
);
  localparam int unsigned NUM_SYMBOLS = DATA_WIDTH / SYMBOL_WIDTH;
  localparam logic [ADDRESS_WIDTH:0]   DepthExt = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(DEPTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  // Marks the first edge after reset so a reset sweep can be skipped.
  logic                     first_q;
  logic                     wr_wait;
  logic                     sweep_wr;
  logic                     wr_accept;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]    rd_d  [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0]    rd_q  [NUM_RD_PORTS];
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_flat;

  assign wr_wait   = (state_q == StSweep);
  assign sweep_wr  = wr_wait && (CLEAR_ON_RESET || !first_q);
  // clear wins over a simultaneous write; out-of-range writes are dropped.
  assign wr_accept = bus.wr_write && !wr_wait && !bus.clear &&
                     ({1'b0, bus.wr_address} < DepthExt);

  // Next state of the sweep controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.clear) begin
          state_d = StSweep;
          cnt_d   = LastAddr;
        end
      end
      StSweep: begin
        if (!sweep_wr || cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - ADDRESS_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sweep controller state; reset parks it at the top of a fresh sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StSweep;
      cnt_q   <= LastAddr;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= 1'b0;
    end
  end

  // Storage array: sweep writes whole words, normal writes only the enabled symbols.
  always_ff @(posedge clk) begin
    if (sweep_wr) begin
      mem_q[cnt_q] <= CLEAR_VALUE;
    end else if (wr_accept) begin
      for (int s = 0; s < NUM_SYMBOLS; s++) begin
        if (bus.wr_byteenable[s]) begin
          mem_q[bus.wr_address][s*SYMBOL_WIDTH +: SYMBOL_WIDTH] <=
            bus.wr_writedata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        end
      end
    end
  end

  // Value a read port will hold after the edge: old memory word with the same-cycle
  // write forwarded symbol by symbol.
  function automatic logic [DATA_WIDTH-1:0] read_next(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] word;
    if (wr_wait) return CLEAR_VALUE;
    if ({1'b0, addr} >= DepthExt) return '0;
    word = mem_q[addr];
    if (wr_accept && (bus.wr_address == addr)) begin
      for (int s = 0; s < NUM_SYMBOLS; s++) begin
        if (bus.wr_byteenable[s]) begin
          word[s*SYMBOL_WIDTH +: SYMBOL_WIDTH] = bus.wr_writedata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        end
      end
    end
    return word;
  endfunction

  // Per-port merged read data ahead of the output register.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_d[p] = read_next(bus.rd_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) rd_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) rd_q[p] <= rd_d[p];
    end
  end

  // Flatten the per-port registers onto the bus.
  always_comb begin
    rd_flat = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_flat[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
    end
  end

  assign bus.rd_readdata    = rd_flat;
  assign bus.wr_waitrequest = wr_wait;
endmodule

// File: tb/tb_demo_de0_sys_lookahead_state_ram_mp.sv
// Scoreboard bench: the driver pushes expected responses from a word-level model, a
// monitor pops and compares one entry after every clock edge.
module tb_demo_de0_sys_lookahead_state_ram_mp;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NP = 3;
  localparam int NS = 2;
  localparam int DEPTH = 5;
  localparam logic [15:0] CV = 16'h00A5;

  typedef struct {
    logic [NP*DW-1:0] rd;
    logic             wr_wait;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  demo_de0_sys_lookahead_state_ram_mp_if #(
    .DATA_WIDTH(DW), .NUM_SYMBOLS(NS), .ADDRESS_WIDTH(AW), .NUM_RD_PORTS(NP)
  ) bus ();

  demo_de0_sys_lookahead_state_ram_mp #(
    .DATA_WIDTH(DW), .SYMBOL_WIDTH(8), .DEPTH(DEPTH), .NUM_RD_PORTS(NP),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mem_m[DEPTH];
  int          busy_left = 0;

  task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle (called at a falling edge), record the expected response, wait a cycle.
  task automatic cycle(input logic clr, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
    exp_t        e;
    logic [2:0]  ra[NP];
    logic [15:0] v;
    logic        waiting, acc;
    bus.clear = clr;
    bus.wr_write = we;
    bus.wr_address = wa;
    bus.wr_writedata = wd;
    bus.wr_byteenable = be;
    bus.rd_address = {r2, r1, r0};
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    waiting = (busy_left > 0);
    acc = we && !waiting && !clr && (int'(wa) < DEPTH);
    for (int p = 0; p < NP; p++) begin
      if (waiting) v = CV;
      else if (int'(ra[p]) >= DEPTH) v = 16'h0000;
      else begin
        v = mem_m[ra[p]];
        if (acc && wa == ra[p]) begin
          if (be[0]) v[7:0] = wd[7:0];
          if (be[1]) v[15:8] = wd[15:8];
        end
      end
      e.rd[p*DW +: DW] = v;
    end
    // Whole-memory effect of a clear is applied at once; it is invisible until the sweep ends.
    if (waiting) busy_left--;
    else if (clr) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
    end else if (acc) begin
      if (be[0]) mem_m[wa][7:0] = wd[7:0];
      if (be[1]) mem_m[wa][15:8] = wd[15:8];
    end
    e.wr_wait = (busy_left > 0);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, r0, r1, r2);
  endtask

  // Monitor: one expected entry per edge once stimulus is running.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp("sb_rd_readdata", bus.rd_readdata, mon_e.rd);
      cmp("sb_wr_waitrequest", 48'(bus.wr_waitrequest), 48'(mon_e.wr_wait));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    bus.clear = 1'b0;
    bus.wr_write = 1'b0;
    bus.wr_address = '0;
    bus.wr_writedata = '0;
    bus.wr_byteenable = '0;
    bus.rd_address = '0;
    repeat (3) @(negedge clk);
    cmp("reset_waitrequest", 48'(bus.wr_waitrequest), 48'd1);
    cmp("reset_readdata", bus.rd_readdata, 48'h0);

    reset_n = 1'b1;
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;

    // Reset sweep length.
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.wr_waitrequest) hi++;
      idle_read(3'd0, 3'd0, 3'd0);
    end
    cmp("reset_sweep_edges", 48'(hi), 48'd5);
    for (int i = 0; i < DEPTH; i++) begin
      idle_read(3'(i), 3'(i), 3'(i));
      cmp("init_read", bus.rd_readdata, {3{CV}});
    end

    // Full-word write forwarded to port 1 only.
    cycle(1'b0, 1'b1, 3'd2, 16'h1234, 2'b11, 3'd3, 3'd2, 3'd3);
    cmp("fwd_full_p1", 48'(bus.rd_readdata[31:16]), 48'h1234);
    cmp("fwd_full_p0", 48'(bus.rd_readdata[15:0]), 48'h00A5);
    cmp("fwd_full_p2", 48'(bus.rd_readdata[47:32]), 48'h00A5);

    // Partial write forwarded to every port, then seen through memory.
    cycle(1'b0, 1'b1, 3'd4, 16'hBEEF, 2'b11, 3'd0, 3'd1, 3'd2);
    cycle(1'b0, 1'b1, 3'd4, 16'h55AA, 2'b01, 3'd4, 3'd4, 3'd4);
    cmp("fwd_partial", bus.rd_readdata, {3{16'hBEAA}});
    idle_read(3'd4, 3'd4, 3'd4);
    cmp("mem_partial", bus.rd_readdata, {3{16'hBEAA}});

    // Runtime clear with a simultaneous write, then a write attempted mid-sweep.
    cycle(1'b1, 1'b1, 3'd0, 16'hFFFF, 2'b11, 3'd0, 3'd1, 3'd2);
    hi = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.wr_waitrequest) hi++;
      cycle(1'b0, i == 2, 3'd3, 16'h2222, 2'b11, 3'd0, 3'd3, 3'd4);
      if (i < 5) cmp("sweep_read", bus.rd_readdata, {3{CV}});
    end
    cmp("clear_sweep_edges", 48'(hi), 48'd5);
    idle_read(3'd0, 3'd3, 3'd4);
    cmp("after_clear", bus.rd_readdata, {3{CV}});

    // Out-of-range read and write.
    idle_read(3'd7, 3'd2, 3'd5);
    cmp("oor_read_p0", 48'(bus.rd_readdata[15:0]), 48'h0);
    cmp("oor_read_p2", 48'(bus.rd_readdata[47:32]), 48'h0);
    cycle(1'b0, 1'b1, 3'd6, 16'h1111, 2'b11, 3'd6, 3'd6, 3'd6);
    cmp("oor_write_read", bus.rd_readdata, 48'h0);
    for (int i = 0; i < DEPTH; i++) begin
      idle_read(3'(i), 3'(i), 3'(i));
      cmp("oor_write_nochange", bus.rd_readdata, {3{CV}});
    end

    // Randomised stress.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle_read(3'd0, 3'd1, 3'd2);

    cmp("queue_drained", 48'(q.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demo_de0_sys_lookahead_state_ram_mp.md
# demo_de0_sys_lookahead_state_ram_mp

Parametrised lookahead state memory with one write port, NUM_RD_PORTS independent read ports, symbol-level write enables, and an initialisation sweep that runs after reset and on a runtime clear request. Every read has one-cycle registered latency. A write to the same address in the cycle a read address is presented is forwarded to that read's data, so the read never returns stale data. It holds per-channel state for the data-format adapters and packet converters in the demo_de0_sys fabric.

## Interface
Parameters:
- DATA_WIDTH, 2: width of each memory word.
- SYMBOL_WIDTH, DATA_WIDTH: byte-enable granularity. DATA_WIDTH must be an integer multiple of it. NUM_SYMBOLS = DATA_WIDTH/SYMBOL_WIDTH.
- DEPTH, 1: number of words. Need not be a power of 2.
- ADDRESS_WIDTH, max(1, clog2(DEPTH)): derived. Do not override.
- NUM_RD_PORTS, 1: number of read ports, 1..8.
- CLEAR_ON_RESET, 1: if 1, sweep-write CLEAR_VALUE into every word after reset release.
- CLEAR_VALUE, 0: DATA_WIDTH value written by every sweep.

Ports:
- clk  in  1  sole clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  request a runtime sweep, sampled when wr_waitrequest=0.
- wr_address  in  ADDRESS_WIDTH  write address.
- wr_writedata  in  DATA_WIDTH  write data.
- wr_byteenable  in  NUM_SYMBOLS  symbol s covers bits [s*SYMBOL_WIDTH +: SYMBOL_WIDTH].
- wr_write  in  1  write strobe.
- wr_waitrequest  out  1  high while a sweep is in progress or in reset. Reset value 1.
- rd_address  in  NUM_RD_PORTS*ADDRESS_WIDTH  port p uses slice [p*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- rd_readdata  out  NUM_RD_PORTS*DATA_WIDTH  port p uses slice [p*DATA_WIDTH +: DATA_WIDTH]. Registered. Reset value 0.

## Operation
- State: IDLE or SWEEP, plus sweep counter cnt (ADDRESS_WIDTH bits).
- In reset: SWEEP, cnt=DEPTH-1, wr_waitrequest=1, all bypass flags 0, all rd_readdata 0.
- After reset, CLEAR_ON_RESET=1:
  - each edge in SWEEP writes CLEAR_VALUE to mem[cnt] with all symbols enabled.
  - if cnt>0, then cnt decrements.
  - if cnt=0, the state moves to IDLE and wr_waitrequest falls on that edge.
- After reset, CLEAR_ON_RESET=0: no sweep writes; the state moves to IDLE at the first edge.
- clear=1 in IDLE starts a sweep: at the edge the state becomes SWEEP, cnt=DEPTH-1, wr_waitrequest=1.
  - clear during SWEEP is ignored; the sweep does not restart.
- Writes are accepted only when wr_write=1, wr_waitrequest=0, clear=0 and wr_address<DEPTH.
  - Writes in any other case are dropped silently. clear has priority over a simultaneous write.
  - An accepted write updates only the enabled symbols of mem[wr_address].
- Read port p, per edge:
  - registers mem[rd_address_p] (read-old-data);
  - registers hit_p = accepted write AND wr_address==rd_address_p;
  - registers the write data and byte enables;
  - registers oor_p = rd_address_p>=DEPTH;
  - registers busy = wr_waitrequest.
- Output merge for port p, in priority order:
  - busy=1: output CLEAR_VALUE.
  - else oor_p=1: output 0.
  - else, for each symbol s: if hit_p and registered byteenable[s], take the registered write symbol; otherwise take the memory symbol.
- All read ports are independent. Any number of ports may read the same address as the write port.

## Timing
- Read latency is 1 cycle. rd_address_p presented in cycle n appears on rd_readdata_p in cycle n+1 and holds until the next edge.
- Lookahead: an accepted write in cycle n to the address read in cycle n is visible in cycle n+1. Unwritten symbols show the old contents.
- A write in cycle n is visible through memory to reads presented in cycle n+1 or later.
- wr_waitrequest after reset release: DEPTH edges high if CLEAR_ON_RESET=1, else 1 edge.
- wr_waitrequest after clear accepted at edge k: it rises at k and falls at edge k+DEPTH.
- Reset mid-sweep: the sweep restarts from DEPTH-1. Memory contents are not guaranteed until the sweep completes.
- Reads issued while wr_waitrequest=1 return CLEAR_VALUE one cycle later.

## Test plan
Bench parameters: DATA_WIDTH=16, SYMBOL_WIDTH=8, DEPTH=5, NUM_RD_PORTS=3, CLEAR_VALUE=16'h00A5.
- Reset release: wr_waitrequest stays 1 for exactly 5 edges. Then reading addresses 0..4 on all ports returns 16'h00A5 each.
- Write 16'h1234 to address 2 with byteenable 2'b11, while port 1 reads address 2 in the same cycle. Next cycle, port 1 shows 16'h1234 and ports 0 and 2, reading address 3, show 16'h00A5.
- Address 4 holds 16'hBEEF. Write 16'h55AA to address 4 with byteenable 2'b01, while all ports read address 4. Next cycle, all ports show 16'hBEAA, and later reads also return 16'hBEAA.
- Pulse clear together with a write of 16'hFFFF to address 0. The write is dropped and wr_waitrequest is high for 5 edges. A write attempted mid-sweep is dropped. Reads during the sweep return 16'h00A5, and after the sweep address 0 reads 16'h00A5.
- Read address 7 on port 0 returns 16'h0000. A write of 16'h1111 to address 6 is dropped, with no change to any valid address.
- Randomised stress, 400 cycles: random writes, byte enables, 3 read addresses and occasional clear. A scoreboard model with 1-cycle latency and lookahead merge matches on every port and every cycle.
